// File: rtl/alu_seq_32_bit.sv
// Registered 32-bit ALU stage: latches operands on start, evaluates logic/arith ops in
// one EXEC cycle, or runs a 32-iteration restoring division for unsigned MOD.
module alu_seq_32_bit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero,
  output logic        busy,
  output logic        done
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, EXEC, DIV} state_t;

  state_t              state, state_next;
  logic [DATA_W-1:0]   a_l, b_l, q, rem, rem_next, exec_res, fin_res;
  logic [2:0]          op_l;
  logic [4:0]          cnt;
  logic [DATA_W:0]     t, diff;
  logic                accept, finish;

  function automatic logic [DATA_W-1:0] alu_fn(input logic [2:0] f,
                                               input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
    logic signed [DATA_W-1:0] xs;
    logic signed [DATA_W-1:0] ys;
    logic [DATA_W-1:0]        r;
    xs = x;
    ys = y;
    case (f)
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b010:  r = x ^ y;
      3'b011:  r = ~(x | y);
      3'b100:  r = x + y;
      3'b101:  r = x - y;
      3'b110:  r = (xs < ys) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One restoring-division step; t - b always fits in 32 bits because rem < b.
  always_comb begin
    t        = {rem, q[DATA_W-1]};
    diff     = t - {1'b0, b_l};
    rem_next = (t >= {1'b0, b_l}) ? diff[DATA_W-1:0] : t[DATA_W-1:0];
    exec_res = alu_fn(op_l, a_l, b_l);
    fin_res  = (state == DIV) ? rem_next : exec_res;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (op == 3'b111) ? DIV : EXEC;
        end
      end
      EXEC: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      DIV: begin
        if (cnt == 5'd31) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result <= '0;
      zero   <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      rem    <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        busy <= 1'b1;
        rem  <= '0;
        cnt  <= '0;
      end
      if (state == DIV) begin
        rem <= rem_next;
        cnt <= cnt + 5'd1;
      end
      if (finish) begin
        busy   <= 1'b0;
        done   <= 1'b1;
        result <= fin_res;
        zero   <= (fin_res == '0);
      end
    end
  end

  // Operand and quotient registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_l  <= a;
      b_l  <= b;
      op_l <= op;
      q    <= a;
    end else if (state == DIV) begin
      q <= {q[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: doc/alu_seq_32_bit.md
# alu_seq_32_bit

Registered 32-bit ALU stage that captures operands on a start handshake and evaluates eight operations. It consumes the combinational 32-bit bitwise units (AND, OR, XOR, NOR) and the adder/subtractor. It registers the selected result and adds a 32-iteration restoring-division datapath for unsigned MOD. It sits between the operand/control logic and the register-file write-back, presenting one registered result plus a done pulse per request.

## Interface

- No parameters; width fixed at 32.
- clk        input   1    single clock; all state updates on rising edge
- reset_n    input   1    synchronous, active-low reset; sampled on rising edge of clk
- start      input   1    request; sampled only while busy=0
- op         input   3    000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLT, 111 MOD
- a          input   32   operand A; captured with start
- b          input   32   operand B; captured with start
- result     output  32   registered result; holds until next completion
- zero       output  1    registered; 1 when the value written to result is 0
- busy       output  1    1 from the edge after start acceptance until the completion edge
- done       output  1    one-cycle pulse, coincident with the first cycle result is valid

## Operation

- State machine: IDLE, EXEC, DIV.
- IDLE:
  - start=1 latches a, b and op into internal registers, and sets busy=1.
  - Next state is DIV if op=111, otherwise EXEC.
  - start=0: remain in IDLE.
- EXEC:
  - Compute the combinational function of the latched operands.
  - Write result and zero, pulse done, clear busy, and return to IDLE.
- DIV:
  - Load rem=0, quotient shift register q=a_latched and iteration counter cnt=0 on entry.
  - Each cycle:
    - t = {rem, q[31]} (33 bit).
    - If t >= {1'b0, b_latched}, then rem = t - b_latched; otherwise rem = t[31:0].
    - q = q << 1.
    - cnt = cnt + 1.
  - On the iteration where cnt=31, write the new rem to result, set zero, pulse done, clear busy, and go to IDLE.
- Arithmetic rules:
  - ADD and SUB are modulo 2^32; no carry or overflow flag.
  - SLT is a signed compare: result = 32'd1 if $signed(a) < $signed(b), else 0.
  - MOD is unsigned. b=0 yields result = a, since every compare passes and the full dividend shifts through. There is no special-case path.
- start while busy=1 is ignored and is not queued.
- start asserted on the same cycle done is high is accepted, because busy=0 in that cycle.
- Latched operands are used throughout. Changing a, b or op after acceptance has no effect.
- Reset (reset_n=0 at a rising edge):
  - state=IDLE.
  - result=0, zero=1, busy=0, done=0.
  - cnt=0 and rem=0.
  - Reset in EXEC or DIV aborts the operation; no done is produced.

## Timing

- Edge E0 samples start=1 in IDLE; busy=1 after E0.
- Non-MOD ops: completion edge E1. result, zero and done=1 are valid after E1. busy=0 after E1. Latency is 2 cycles from start to result.
- MOD: 32 DIV cycles at edges E1..E32. result and done are valid after E32, and busy=0 after E32.
- done is high for exactly one cycle after the completion edge, then 0.
- Throughput:
  - Back-to-back non-MOD ops accept a new start every 2 cycles.
  - Back-to-back MOD ops accept a new start every 33 cycles.
- result and zero change only at completion edges and at reset.

## Test plan

- Reset: hold reset_n=0 for 2 cycles with start=1 -> result=0, zero=1, busy=0, done=0, and no acceptance.
- OR and AND:
  - a=0xF0F00000, b=0x00000F0F, op=001 -> done 2 cycles after start, result=0xF0F00F0F, zero=0.
  - Repeat with op=000 -> result=0, zero=1.
- ADD, SUB and SLT:
  - 0xFFFFFFFF + 1 -> result=0, zero=1.
  - 5 - 7 -> result=0xFFFFFFFE.
  - SLT with a=0xFFFFFFFF, b=1 -> result=1.
  - SLT with a=1, b=0xFFFFFFFF -> result=0.
- MOD:
  - 100 mod 7 -> result=2, done exactly 33 cycles after start.
  - 0xFFFFFFFF mod 0x10 -> result=0xF.
  - 0x1234 mod 0 -> result=0x1234.
  - 6 mod 3 -> result=0, zero=1.
- Handshake:
  - During a MOD, pulse start with op=001 at iteration 5 -> ignored; only one done, with the MOD result.
  - Assert start with new operands in the done cycle -> accepted, and the second done follows 2 cycles later.
- Reset mid-operation: reset_n=0 at DIV iteration 10 -> no done, result=0, busy=0. The next MOD, 50 mod 8, completes normally with result=2.
